// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared definitions for the 4x4 matrix keypad responder:
//             FSM state encoding, idle row value, and the key-code to
//             (column, row) mapping used by both the emulator and the
//             scanner-side decode table.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Press sequencer states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] ST_HOLD       = 3'd2;
    localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    // Row lines are active-low; nothing pulled means all ones
    localparam logic [3:0] ROW_IDLE = 4'hF;

    // Column index of a key: the scanner numbers columns in reverse of the
    // low key bits.
    function automatic logic [1:0] key_col(input logic [3:0] key);
        return 2'd3 - key[1:0];
    endfunction

    // Row index of a key from its upper two bits.
    function automatic logic [1:0] key_row(input logic [3:0] key);
        logic [1:0] r;
        case (key[3:2])
            2'b11:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b10:   r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Active-low one-hot pattern for a line index.
    function automatic logic [3:0] line_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kp_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : kp_tick_gen
//  Purpose  : Free-running prescaler producing a one-cycle tick every
//             TICK_DIV clock cycles, with a synchronous clear that restarts
//             the count from zero.
//  Ports    : i_clk   - clock
//             i_rst_n - asynchronous active-low reset
//             clr     - synchronous clear (count returns to 0 next cycle)
//             tick    - high on the last cycle of each TICK_DIV window
//  Revision : 1.0 - initial release
// ============================================================================
module kp_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_emulator
//  Purpose  : Responder-side model of a 4x4 active-low matrix keypad. A
//             press request (key code + hold time) is played out as make
//             bounce, hold, break bounce and a released gap; the modelled
//             contact pulls the key's row low while its column is strobed.
//  Ports    : i_clk     - system clock
//             i_rst_n   - asynchronous active-low reset
//             col       - column strobes from the scanner (active-low)
//             row       - row lines to the scanner (active-low, idle 4'hF)
//             req_valid - press request valid
//             req_ready - high only while idle
//             req_key   - key code in scanner encoding
//             req_hold  - hold time in ticks (0 behaves as 1)
//             abort     - cancel current press, jump to the gap phase
//             busy      - high whenever a press is in progress
//             done      - one-cycle pulse when a press sequence completes
//             contact   - current modelled switch state
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_TICKS   = 1,
    parameter int GAP_TICKS      = 20,
    parameter int HOLD_W         = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              contact
);

    // ------------------------------------------------------------------
    // Counter sizing: the phase tick counter must reach the largest
    // terminal value of any phase.
    // ------------------------------------------------------------------
    localparam int BOUNCE_TOTAL = BOUNCE_TOGGLES * BOUNCE_TICKS;
    localparam int GAP_W        = $clog2(GAP_TICKS + 1);
    localparam int BNC_W        = $clog2(BOUNCE_TOTAL + 1);
    localparam int CNT_W0       = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
    localparam int CNT_W        = (CNT_W0 > BNC_W) ? CNT_W0 : BNC_W;
    localparam int SUB_W        = (BOUNCE_TICKS < 2) ? 1 : $clog2(BOUNCE_TICKS);

    localparam logic [CNT_W-1:0] BOUNCE_LAST =
        CNT_W'((BOUNCE_TOTAL > 0) ? BOUNCE_TOTAL - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BOUNCE_TICKS - 1);
    localparam logic             HAS_BOUNCE = (BOUNCE_TOTAL > 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_q,    state_d;
    logic              contact_q,  contact_d;
    logic [1:0]        col_sel_q,  col_sel_d;
    logic [1:0]        row_sel_q,  row_sel_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SUB_W-1:0]  sub_cnt_q,  sub_cnt_d;
    logic              done_q,     done_d;

    logic              tick;
    logic              tick_clr;
    logic [CNT_W-1:0]  last_val;
    logic              at_last;
    logic              sub_last;
    logic              in_bounce;

    // Prescaler restarts on every state entry and is held clear while idle,
    // so each phase lasts an exact multiple of TICK_DIV cycles.
    assign tick_clr = (state_d != state_q) || (state_q == ST_IDLE);

    kp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (tick_clr),
        .tick    (tick)
    );

    // Terminal tick count of the current phase
    always_comb begin
        last_val = '0;
        case (state_q)
            ST_BOUNCE_IN,
            ST_BOUNCE_OUT: last_val = BOUNCE_LAST;
            ST_HOLD:       last_val = CNT_W'(hold_q) - CNT_W'(1);
            ST_GAP:        last_val = GAP_LAST;
            default:       last_val = '0;
        endcase
    end

    assign at_last   = (tick_cnt_q == last_val);
    assign sub_last  = (sub_cnt_q == SUB_LAST);
    assign in_bounce = (state_q == ST_BOUNCE_IN) || (state_q == ST_BOUNCE_OUT);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        contact_d = contact_q;
        col_sel_d = col_sel_q;
        row_sel_d = row_sel_q;
        hold_d    = hold_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    col_sel_d = key_col(req_key);
                    row_sel_d = key_row(req_key);
                    hold_d    = (req_hold == '0) ? HOLD_W'(1) : req_hold;
                    contact_d = 1'b1;
                    state_d   = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
                end
            end

            ST_BOUNCE_IN: begin
                if (abort) begin
                    state_d   = ST_GAP;
                    contact_d = 1'b0;
                end else if (tick) begin
                    if (at_last) begin
                        // Even toggle count leaves the contact open here;
                        // entering the hold phase closes it for good.
                        state_d   = ST_HOLD;
                        contact_d = 1'b1;
                    end else if (sub_last) begin
                        contact_d = ~contact_q;
                    end
                end
            end

            ST_HOLD: begin
                if (abort) begin
                    state_d   = ST_GAP;
                    contact_d = 1'b0;
                end else if (tick && at_last) begin
                    state_d   = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
                    contact_d = 1'b0;
                end
            end

            ST_BOUNCE_OUT: begin
                if (abort) begin
                    state_d   = ST_GAP;
                    contact_d = 1'b0;
                end else if (tick) begin
                    if (at_last) begin
                        state_d   = ST_GAP;
                        contact_d = 1'b0;
                    end else if (sub_last) begin
                        contact_d = ~contact_q;
                    end
                end
            end

            ST_GAP: begin
                contact_d = 1'b0;
                if (tick && at_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    // Phase counters clear on entry and only advance on ticks, so they
    // never run past their terminal value.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        sub_cnt_d  = sub_cnt_q;
        if (state_d != state_q) begin
            tick_cnt_d = '0;
            sub_cnt_d  = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
            if (in_bounce) begin
                sub_cnt_d = sub_last ? '0 : sub_cnt_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            contact_q  <= 1'b0;
            col_sel_q  <= 2'd0;
            row_sel_q  <= 2'd0;
            hold_q     <= '0;
            tick_cnt_q <= '0;
            sub_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            contact_q  <= contact_d;
            col_sel_q  <= col_sel_d;
            row_sel_q  <= row_sel_d;
            hold_q     <= hold_d;
            tick_cnt_q <= tick_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Row responds combinationally to the strobe, like a real switch.
    always_comb begin
        row = ROW_IDLE;
        if (contact_q && !col[col_sel_q]) begin
            row = line_low(row_sel_q);
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign contact   = contact_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_emulator
//  Purpose  : Directed self-checking bench for keypad_emulator with
//             TICK_DIV=4, BOUNCE_TOGGLES=2, BOUNCE_TICKS=1, GAP_TICKS=2.
//             Cycle numbers count from the accept edge as cycle 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_key;
    logic [15:0] req_hold;
    logic        abort;
    logic        busy;
    logic        done;
    logic        contact;

    keypad_emulator #(
        .TICK_DIV       (4),
        .BOUNCE_TOGGLES (2),
        .BOUNCE_TICKS   (1),
        .GAP_TICKS      (2),
        .HOLD_W         (16)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .col       (col),
        .row       (row),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_hold  (req_hold),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .contact   (contact)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and park on the following negedge.
    task automatic step();
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) step();
    endtask

    // Present a request for one edge; returns parked in cycle 1.
    task automatic accept(input logic [3:0] key, input logic [15:0] hold);
        req_valid = 1'b1;
        req_key   = key;
        req_hold  = hold;
        @(posedge i_clk);
        @(negedge i_clk);
        cyc       = 1;
        req_valid = 1'b0;
    endtask

    // Bounded wait for the done pulse; reports the cycle it was seen.
    task automatic wait_done(input int max_cycles, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
    endtask

    function automatic logic exp_contact_h3(input int n);
        return ((n >= 1 && n <= 4) || (n >= 9 && n <= 20) || (n >= 25 && n <= 28));
    endfunction

    initial begin
        logic       seen;
        logic [1:0] c;
        logic [1:0] r;
        logic [3:0] k;
        logic [3:0] exp_row;
        logic [3:0] one4;

        i_rst_n   = 1'b0;
        col       = 4'h0;
        req_valid = 1'b0;
        req_key   = 4'h0;
        req_hold  = 16'd0;
        abort     = 1'b0;
        one4      = 4'b0001;

        // ---------------- reset state ----------------
        @(negedge i_clk);
        @(negedge i_clk);
        check("rst_row",     row,       4'hF);
        check("rst_ready",   req_ready, 1'b1);
        check("rst_busy",    busy,      1'b0);
        check("rst_done",    done,      1'b0);
        check("rst_contact", contact,   1'b0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // ---------------- key 5, hold 3 (+ busy rejection) ----------------
        accept(4'h5, 16'd3);
        for (int n = 1; n <= 36; n++) begin
            goto_cycle(n);
            check($sformatf("k5_contact_c%0d", n), contact, exp_contact_h3(n));
            if (n == 5) begin
                check("rej_ready", req_ready, 1'b0);
                check("rej_busy",  busy,      1'b1);
                req_valid = 1'b1;
                req_key   = 4'h3;
                req_hold  = 16'd1;
            end
            if (n == 6) req_valid = 1'b0;
            if (n == 10) begin
                col = 4'b1011; #1;
                check("k5_row_col1011", row, 4'b1101);
                col = 4'b1110; #1;
                check("k5_row_col1110", row, 4'hF);
                col = 4'h0; #1;
                check("k5_row_col0000", row, 4'b1101);
            end
        end
        check("k5_busy_c36", busy, 1'b1);
        check("k5_done_c36", done, 1'b0);
        goto_cycle(37);
        check("k5_done_c37",  done,      1'b1);
        check("k5_ready_c37", req_ready, 1'b1);
        goto_cycle(38);
        check("k5_done_c38", done, 1'b0);

        // ---------------- hold 0 behaves as 1 tick ----------------
        accept(4'hA, 16'd0);
        goto_cycle(11);
        col = 4'b1101; #1;
        check("kA_row_col1101", row, 4'b1011);
        col = 4'h0;
        goto_cycle(12);
        check("h0_contact_c12", contact, 1'b1);
        goto_cycle(13);
        check("h0_contact_c13", contact, 1'b0);
        goto_cycle(28);
        check("h0_done_c28", done, 1'b0);
        goto_cycle(29);
        check("h0_done_c29", done, 1'b1);
        step();

        // ---------------- abort in HOLD ----------------
        accept(4'hA, 16'd0);
        goto_cycle(9);
        check("ab_contact_c9", contact, 1'b1);
        goto_cycle(12);
        check("ab_contact_c12", contact, 1'b1);
        abort = 1'b1;
        goto_cycle(13);
        abort = 1'b0;
        for (int n = 13; n <= 20; n++) begin
            goto_cycle(n);
            check($sformatf("ab_contact_c%0d", n), contact, 1'b0);
            check($sformatf("ab_done_c%0d", n), done, 1'b0);
        end
        check("ab_busy_c20", busy, 1'b1);
        goto_cycle(21);
        check("ab_done_c21", done, 1'b1);
        check("ab_busy_c21", busy, 1'b0);
        step();

        // ---------------- reset mid-press ----------------
        accept(4'h5, 16'd3);
        goto_cycle(15);
        check("mr_row_pre", row, 4'b1101);
        i_rst_n = 1'b0; #1;
        check("mr_row",     row,       4'hF);
        check("mr_contact", contact,   1'b0);
        check("mr_busy",    busy,      1'b0);
        check("mr_ready",   req_ready, 1'b1);
        step();
        i_rst_n = 1'b1;
        wait_done(45, seen);
        check("mr_no_done", seen, 1'b0);
        accept(4'hC, 16'd1);
        check("mr_new_busy",    busy,    1'b1);
        check("mr_new_contact", contact, 1'b1);
        wait_done(60, seen);
        check("mr_new_done", seen, 1'b1);
        step();

        // ---------------- mapping sweep over all keys ----------------
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            c = 2'd3 - k[1:0];
            case (k[3:2])
                2'b11:   r = 2'd0;
                2'b01:   r = 2'd1;
                2'b10:   r = 2'd2;
                default: r = 2'd3;
            endcase
            exp_row = ~(one4 << r);
            accept(k, 16'd1);
            goto_cycle(10);
            col = ~(one4 << c); #1;
            check($sformatf("map_k%0h_hit", k), row, exp_row);
            col = ~(one4 << (c + 2'd1)); #1;
            check($sformatf("map_k%0h_miss", k), row, 4'hF);
            col = 4'h0;
            wait_done(40, seen);
            check($sformatf("map_k%0h_done", k), seen, 1'b1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
